data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the single data-memory/IO bus (AS_L, WE_L, address, data_out, RAM_Select, IO_Select) between two requesters.
  - M0: the core's load/store port.
  - M1: the program loader/debug port, which clears RAM and writes instructions before the core runs.
- Sequences each access with a fixed-latency strobe FSM and decodes the address into RAM or IO space.
- Sits between the core/loader and the RAM and IO blocks inside risc_v_core.

Parameters:
- ADDR_W, 10, byte-address width of the bus.
- RAM_LAT, 2, cycles AS_L is held low per access; legal range 1-15.
- IO_BASE, 10'h300, first byte address decoded as IO; lower addresses decode as RAM.

Ports:
- CLOCK_50 in 1: system clock.
- RESET_L in 1: reset; asynchronous, active-low.
- m0_req in 1: core request; held until m0_ack.
- m0_we in 1: 1 = write.
- m0_addr in ADDR_W: byte address.
- m0_wdata in 32: write data.
- m0_rdata out 32: read data.
- m0_ack out 1: one-cycle completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as the M0 ports, for the loader.
- AS_L out 1: address strobe, active-low.
- WE_L out 1: write enable, active-low.
- address out ADDR_W: bus address; bits [1:0] always 0.
- data_out out 32: bus write data.
- data_in in 32: bus read data from RAM/IO mux.
- RAM_Select out 1: address is in RAM space.
- IO_Select out 1: address is in IO space.
- busy out 1: high in any state other than IDLE.
- grant_id out 1: owner of the current or last transaction (0 = M0, 1 = M1).

Behaviour:
- Reset (asynchronous, takes effect immediately, even mid-transaction):
  - AS_L=1, WE_L=1, address=0, data_out=0, RAM_Select=0, IO_Select=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, busy=0, grant_id=0.
  - State=IDLE. An aborted transaction never acks.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high: latch winner, we, address (with [1:0] forced to 00), wdata, and selects into output registers; load cnt=RAM_LAT-1; go to ACCESS.
  - AS_L stays 1 on this cycle.
- ACCESS:
  - AS_L=0; WE_L=~we.
  - data_out = wdata on writes, 0 on reads.
  - While cnt>0: decrement cnt.
  - When cnt==0: on reads, capture data_in into the winner's rdata register; go to ACK.
- ACK:
  - AS_L=1, WE_L=1; winner's ack=1 for exactly this cycle; go to IDLE.
- Latency: with req high in IDLE at cycle 0, ack is high in cycle RAM_LAT+1. No back-to-back overlap; throughput is one access per RAM_LAT+2 cycles.
- Handshake:
  - A master keeps req, we, addr and wdata stable until it sees ack.
  - A master that deasserts req registered off ack issues no repeat access.
  - A master still holding req in the IDLE after ACK starts a new transaction.
  - Changing req inputs while not owner has no effect until the next IDLE.
- rdata: holds its value until that master's next read ack; writes do not alter rdata.
- Arbitration (macro absent): fixed priority, M0 wins when both request in the same IDLE cycle.
- Address decode:
  - RAM_Select=1 iff addr < IO_BASE.
  - IO_Select=1 iff addr >= IO_BASE.
  - Exactly one of the two is high during ACCESS; both are 0 in IDLE.
- grant_id and selects are held from IDLE-latch through ACK.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - On a simultaneous request, the master not granted last wins.
  - The last-grant register resets to 1, so M0 wins the first contest.
  - A lone requester always wins regardless of last grant.
- Undefined: fixed M0 priority as above; the last-grant register is not instantiated.

Decomposition:
- Package risc_v_bus_pkg:
  - arb_state_t enum {IDLE, ACCESS, ACK}.
  - BUS_DATA_W=32.
  - Default IO_BASE constant.
  - Shared with the RAM and IO blocks.
- Sub-module bus_addr_decode: combinational; takes addr, produces RAM_Select/IO_Select, parameterised by ADDR_W and IO_BASE; reused by the IO block.

Test Plan:
- M1 write, addr=10'h010, wdata=32'hA5A5_0001, RAM_LAT=2 -> AS_L low cycles 1-2, WE_L low, RAM_Select=1, address=10'h010, m1_ack in cycle 3 only.
- M0 read, addr=10'h013, data_in=32'h1234_5678 -> address=10'h010, WE_L=1, data_out=0, m0_rdata=32'h1234_5678 in ack cycle and held after.
- M0 and M1 req high in the same cycle twice in a row:
  - macro off -> grants M0, M0.
  - ARB_ROUND_ROBIN_EN -> M0 then M1.
  - Every granted transaction acks exactly once.
- M0 write addr=10'h300 -> IO_Select=1, RAM_Select=0; addr=10'h2FC -> RAM_Select=1.
- RESET_L low during ACCESS -> AS_L=1 and WE_L=1 immediately, no ack, busy=0; after release, a new M1 request completes in RAM_LAT+1 cycles.
- Loader clears 256 words (addr 0..1020 step 4) while m0_req is low -> 256 m1_acks, no m0_ack, address increments by 4 per transaction.

Source files
------------

// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the risc_v_core data bus.
// The arbiter, the RAM block and the IO block all import this package.
package risc_v_bus_pkg;

  // Bus data path width
  localparam int BUS_DATA_W = 32;

  // Default byte-address width of the bus
  localparam int BUS_ADDR_W = 10;

  // First byte address that belongs to IO space; lower addresses are RAM
  localparam logic [BUS_ADDR_W-1:0] DEFAULT_IO_BASE = 10'h300;

  // Access counter width; holds RAM_LAT-1 for RAM_LAT in 1..15
  localparam int ARB_CNT_W = 4;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } arb_state_t;

  // Counter load value for an access that holds the strobe for lat cycles
  function automatic logic [ARB_CNT_W-1:0] latToCount(input int lat);
    return ARB_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Bundle of the two requester handshakes plus the shared memory/IO bus.
// slave  : the arbiter's view (takes requests, drives the bus).
// master : the environment's view (requesters, RAM/IO read mux).
interface data_bus_arbiter_if #(
  parameter int ADDR_W = risc_v_bus_pkg::BUS_ADDR_W
);
  import risc_v_bus_pkg::*;

  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_W-1:0]     m0_addr;
  logic [BUS_DATA_W-1:0] m0_wdata;
  logic [BUS_DATA_W-1:0] m0_rdata;
  logic                  m0_ack;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_W-1:0]     m1_addr;
  logic [BUS_DATA_W-1:0] m1_wdata;
  logic [BUS_DATA_W-1:0] m1_rdata;
  logic                  m1_ack;

  logic                  AS_L;
  logic                  WE_L;
  logic [ADDR_W-1:0]     address;
  logic [BUS_DATA_W-1:0] data_out;
  logic [BUS_DATA_W-1:0] data_in;
  logic                  RAM_Select;
  logic                  IO_Select;
  logic                  busy;
  logic                  grant_id;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  data_in,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output AS_L, WE_L, address, data_out, RAM_Select, IO_Select, busy, grant_id
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output data_in,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  AS_L, WE_L, address, data_out, RAM_Select, IO_Select, busy, grant_id
  );

endinterface

// File: rtl/data_bus_arbiter_addr_decode.sv
// Address space decoder: splits the byte address into RAM and IO space.
// Purely combinational so the IO block can reuse it on its own address.
module bus_addr_decode
  import risc_v_bus_pkg::*;
#(
  parameter int                ADDR_W  = BUS_ADDR_W,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(DEFAULT_IO_BASE)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ramSel_o,
  output logic              ioSel_o
);

  // Everything below IO_BASE is RAM, everything at or above is IO
  always_comb begin
    ramSel_o = (addr_i < IO_BASE);
    ioSel_o  = (addr_i >= IO_BASE);
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-requester arbiter for the data memory/IO bus inside risc_v_core.
// M0 is the core load/store port, M1 the program loader/debug port.
// Each access: one IDLE latch cycle, RAM_LAT cycles of strobe, one ACK cycle.
// Optional macro ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous
// requests instead of always favouring M0.
module data_bus_arbiter
  import risc_v_bus_pkg::*;
#(
  parameter int                ADDR_W  = BUS_ADDR_W,
  parameter int                RAM_LAT = 2,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(DEFAULT_IO_BASE)
) (
  input  logic              CLOCK_50,
  input  logic              RESET_L,
  data_bus_arbiter_if.slave arb
);

  arb_state_t            state_q, state_d;
  logic [ARB_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  grantId_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [BUS_DATA_W-1:0] wdata_q;
  logic                  ramSel_q;
  logic                  ioSel_q;
  logic [BUS_DATA_W-1:0] rdata0_q;
  logic [BUS_DATA_W-1:0] rdata1_q;

  logic                  latch;
  logic                  capture;
  logic                  pickM1;
  logic                  anyReq;
  logic                  selWe;
  logic [ADDR_W-1:0]     selAddr;
  logic [BUS_DATA_W-1:0] selWdata;
  logic                  decRam;
  logic                  decIo;

  assign anyReq = arb.m0_req | arb.m1_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrant_q;

  // On a contest hand the bus to whoever did not win last; a lone requester always wins
  always_comb begin
    pickM1 = arb.m1_req;
    if (arb.m0_req && arb.m1_req) pickM1 = ~lastGrant_q;
  end

  // Last winner; resetting to M1 lets M0 take the first contest
  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L)   lastGrant_q <= 1'b1;
    else if (latch) lastGrant_q <= pickM1;
  end
`else
  // Fixed priority: M1 only wins when M0 is not asking
  always_comb begin
    pickM1 = ~arb.m0_req;
  end
`endif

  // Mux the winning request; the bus is word-addressed so the byte offset is dropped
  always_comb begin
    selWe    = pickM1 ? arb.m1_we    : arb.m0_we;
    selWdata = pickM1 ? arb.m1_wdata : arb.m0_wdata;
    selAddr  = pickM1 ? arb.m1_addr  : arb.m0_addr;
    selAddr[1:0] = 2'b00;
  end

  bus_addr_decode #(
    .ADDR_W  (ADDR_W),
    .IO_BASE (IO_BASE)
  ) uDecode (
    .addr_i   (selAddr),
    .ramSel_o (decRam),
    .ioSel_o  (decIo)
  );

  // State and strobe counter registers
  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and bus/handshake outputs, all decoded from the current state
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    latch          = 1'b0;
    capture        = 1'b0;
    arb.AS_L       = 1'b1;
    arb.WE_L       = 1'b1;
    arb.data_out   = '0;
    arb.RAM_Select = 1'b0;
    arb.IO_Select  = 1'b0;
    arb.m0_ack     = 1'b0;
    arb.m1_ack     = 1'b0;
    arb.busy       = (state_q != IDLE);
    arb.grant_id   = grantId_q;
    arb.address    = addr_q;
    arb.m0_rdata   = rdata0_q;
    arb.m1_rdata   = rdata1_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          latch   = 1'b1;
          cnt_d   = latToCount(RAM_LAT);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        arb.AS_L       = 1'b0;
        arb.WE_L       = ~we_q;
        arb.data_out   = we_q ? wdata_q : '0;
        arb.RAM_Select = ramSel_q;
        arb.IO_Select  = ioSel_q;
        if (cnt_q == '0) begin
          capture = ~we_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        arb.RAM_Select = ramSel_q;
        arb.IO_Select  = ioSel_q;
        arb.m0_ack     = ~grantId_q;
        arb.m1_ack     = grantId_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch in IDLE and read-data capture on the last strobe cycle
  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      grantId_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ramSel_q  <= 1'b0;
      ioSel_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (latch) begin
        grantId_q <= pickM1;
        we_q      <= selWe;
        addr_q    <= selAddr;
        wdata_q   <= selWdata;
        ramSel_q  <= decRam;
        ioSel_q   <= decIo;
      end
      if (capture) begin
        if (grantId_q) rdata1_q <= arb.data_in;
        else           rdata0_q <= arb.data_in;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Testbench for data_bus_arbiter: directed scenarios plus randomized
// request mixes checked against a transaction-level reference model.
module tb_data_bus_arbiter;
  import risc_v_bus_pkg::*;

  localparam int         ADDR_W  = 10;
  localparam int         RAM_LAT = 2;
  localparam logic [9:0] IO_BASE = 10'h300;

  logic clk = 1'b0;
  logic rstL;
  always #10 clk = ~clk;

  data_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  data_bus_arbiter #(
    .ADDR_W  (ADDR_W),
    .RAM_LAT (RAM_LAT),
    .IO_BASE (IO_BASE)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_L  (rstL),
    .arb      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: last winner and each master's visible read data
  bit          modelLast = 1'b1;
  logic [31:0] expRdata [2] = '{32'h0, 32'h0};

  // Observations of one transaction, filled by waitAck
  int          obsCycles, obsAsLow, obsFirstLow;
  logic        obsWho, obsWeL, obsRam, obsIo, obsGrant, obsBothAck;
  logic [9:0]  obsAddr;
  logic [31:0] obsDout, obsR0, obsR1;
  logic [1:0]  obsStrobeAtAck;

  // Arbitration rule from the requester's point of view
  function automatic bit predictWinner(input bit r0, input bit r1, input bit last);
`ifdef ARB_ROUND_ROBIN_EN
    if (r0 && r1) return ~last;
    return r1;
`else
    return r0 ? 1'b0 : 1'b1;
`endif
  endfunction

  // Raise a request on master m with the given access
  task automatic applyStimulus(input bit m, input logic we, input logic [9:0] addr, input logic [31:0] wdata);
    if (m) begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  task automatic dropReq(input bit m);
    if (m) bus.m1_req = 1'b0;
    else   bus.m0_req = 1'b0;
  endtask

  // Watch negedges until an ack appears (or budget runs out), recording the bus activity
  task automatic waitAck(input int budget);
    obsCycles = 0; obsAsLow = 0; obsFirstLow = 0; obsBothAck = 1'b0;
    obsWho = 1'bx; obsWeL = 1'bx; obsRam = 1'bx; obsIo = 1'bx; obsGrant = 1'bx;
    obsAddr = 'x; obsDout = 'x; obsR0 = 'x; obsR1 = 'x; obsStrobeAtAck = 'x;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.AS_L === 1'b0) begin
        obsAsLow++;
        if (obsFirstLow == 0) obsFirstLow = k;
        obsWeL = bus.WE_L; obsAddr = bus.address; obsDout = bus.data_out;
        obsRam = bus.RAM_Select; obsIo = bus.IO_Select;
      end
      if (bus.m0_ack === 1'b1 && bus.m1_ack === 1'b1) obsBothAck = 1'b1;
      if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
        obsCycles = k; obsWho = bus.m1_ack; obsGrant = bus.grant_id;
        obsR0 = bus.m0_rdata; obsR1 = bus.m1_rdata;
        obsStrobeAtAck = {bus.AS_L, bus.WE_L};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstL = 1'b0;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.AS_L, bus.WE_L, bus.RAM_Select, bus.IO_Select} !== 4'b1100) begin
      errors++; $display("[TB] FAIL reset_strobes got %b want 1100", {bus.AS_L, bus.WE_L, bus.RAM_Select, bus.IO_Select});
    end
    checks++;
    if ({bus.m0_ack, bus.m1_ack, bus.busy, bus.grant_id} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_status got %b want 0000", {bus.m0_ack, bus.m1_ack, bus.busy, bus.grant_id});
    end
    checks++;
    if (bus.address !== 10'h0 || bus.data_out !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_bus got addr=%h dout=%h want 0 0", bus.address, bus.data_out);
    end
    checks++;
    if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_rdata got %h %h want 0 0", bus.m0_rdata, bus.m1_rdata);
    end
    rstL = 1'b1;
    modelLast = 1'b1;
  endtask

  task automatic test_m1_write();
    bus.data_in = 32'h0BAD_F00D;
    applyStimulus(1'b1, 1'b1, 10'h010, 32'hA5A5_0001);
    waitAck(20);
    checks++;
    if (obsCycles !== RAM_LAT + 1 || obsWho !== 1'b1 || obsGrant !== 1'b1) begin
      errors++; $display("[TB] FAIL m1w_ack got cyc=%0d who=%b gnt=%b want cyc=%0d who=1 gnt=1", obsCycles, obsWho, obsGrant, RAM_LAT + 1);
    end
    checks++;
    if (obsFirstLow !== 1 || obsAsLow !== RAM_LAT || obsWeL !== 1'b0 || obsStrobeAtAck !== 2'b11) begin
      errors++; $display("[TB] FAIL m1w_strobe got first=%0d n=%0d weL=%b atAck=%b want 1 %0d 0 11", obsFirstLow, obsAsLow, obsWeL, obsStrobeAtAck, RAM_LAT);
    end
    checks++;
    if (obsAddr !== 10'h010 || obsDout !== 32'hA5A5_0001 || {obsRam, obsIo} !== 2'b10) begin
      errors++; $display("[TB] FAIL m1w_bus got addr=%h dout=%h sel=%b%b want 010 a5a50001 10", obsAddr, obsDout, obsRam, obsIo);
    end
    checks++;
    if (obsR1 !== expRdata[1]) begin
      errors++; $display("[TB] FAIL m1w_rdata got %h want %h", obsR1, expRdata[1]);
    end
    dropReq(1'b1); modelLast = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.RAM_Select, bus.IO_Select, bus.m0_ack, bus.m1_ack} !== 5'b0) begin
      errors++; $display("[TB] FAIL m1w_idle got %b want 00000", {bus.busy, bus.RAM_Select, bus.IO_Select, bus.m0_ack, bus.m1_ack});
    end
  endtask

  task automatic test_m0_read();
    bus.data_in = 32'h1234_5678;
    applyStimulus(1'b0, 1'b0, 10'h013, 32'hFFFF_FFFF);
    waitAck(20);
    checks++;
    if (obsCycles !== RAM_LAT + 1 || obsWho !== 1'b0) begin
      errors++; $display("[TB] FAIL m0r_ack got cyc=%0d who=%b want %0d 0", obsCycles, obsWho, RAM_LAT + 1);
    end
    checks++;
    if (obsAddr !== 10'h010 || obsWeL !== 1'b1 || obsDout !== 32'h0) begin
      errors++; $display("[TB] FAIL m0r_bus got addr=%h weL=%b dout=%h want 010 1 0", obsAddr, obsWeL, obsDout);
    end
    checks++;
    if (obsR0 !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL m0r_rdata_ack got %h want 12345678", obsR0);
    end
    dropReq(1'b0); expRdata[0] = 32'h1234_5678; modelLast = 1'b0;
    bus.data_in = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.m0_rdata !== 32'h1234_5678 || bus.m1_rdata !== expRdata[1]) begin
      errors++; $display("[TB] FAIL m0r_rdata_hold got %h %h want 12345678 %h", bus.m0_rdata, bus.m1_rdata, expRdata[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] din;
    bit w;
    din = $urandom;
    bus.data_in = din;
    applyStimulus(1'b0, 1'b0, 10'h020, 32'h0);
    applyStimulus(1'b1, 1'b1, 10'h024, $urandom);
    for (int t = 0; t < 2; t++) begin
      w = predictWinner(1'b1, 1'b1, modelLast);
      waitAck(20);
      checks++;
      if (obsWho !== w || obsCycles !== (t == 0 ? RAM_LAT + 1 : RAM_LAT + 2) || obsBothAck !== 1'b0) begin
        errors++; $display("[TB] FAIL contest%0d got who=%b cyc=%0d both=%b want who=%b", t, obsWho, obsCycles, obsBothAck, w);
      end
      modelLast = w;
      if (!w) expRdata[0] = din;
      checks++;
      if (obsR0 !== expRdata[0] || obsR1 !== expRdata[1]) begin
        errors++; $display("[TB] FAIL contest%0d_rdata got %h %h want %h %h", t, obsR0, obsR1, expRdata[0], expRdata[1]);
      end
    end
    dropReq(w);
    w = ~w;
    waitAck(20);
    checks++;
    if (obsWho !== w || obsCycles !== RAM_LAT + 2) begin
      errors++; $display("[TB] FAIL contest_tail got who=%b cyc=%0d want who=%b cyc=%0d", obsWho, obsCycles, w, RAM_LAT + 2);
    end
    modelLast = w;
    if (!w) expRdata[0] = din;
    dropReq(w);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.m0_ack, bus.m1_ack} !== 3'b0) begin
      errors++; $display("[TB] FAIL contest_single_ack got %b want 000", {bus.busy, bus.m0_ack, bus.m1_ack});
    end
  endtask

  task automatic test_io_decode();
    logic [9:0]  addrs [2] = '{10'h300, 10'h2FC};
    logic [1:0]  sels  [2] = '{2'b01, 2'b10};
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, addrs[i], 32'hC0DE_0000 + i);
      waitAck(20);
      checks++;
      if ({obsRam, obsIo} !== sels[i] || obsAddr !== addrs[i] || obsWho !== 1'b0) begin
        errors++; $display("[TB] FAIL decode_%h got sel=%b%b addr=%h who=%b want %b", addrs[i], obsRam, obsIo, obsAddr, obsWho, sels[i]);
      end
      dropReq(1'b0); modelLast = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.RAM_Select, bus.IO_Select} !== 2'b00) begin
        errors++; $display("[TB] FAIL decode_idle got %b want 00", {bus.RAM_Select, bus.IO_Select});
      end
    end
  endtask

  task automatic test_reset_mid();
    int ackSeen;
    logic [31:0] din;
    applyStimulus(1'b1, 1'b1, 10'h040, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (bus.AS_L !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_pre got AS_L=%b want 0", bus.AS_L);
    end
    #3 rstL = 1'b0;
    #1;
    checks++;
    if ({bus.AS_L, bus.WE_L, bus.busy, bus.m0_ack, bus.m1_ack} !== 5'b11000) begin
      errors++; $display("[TB] FAIL rstmid_async got %b want 11000", {bus.AS_L, bus.WE_L, bus.busy, bus.m0_ack, bus.m1_ack});
    end
    dropReq(1'b1);
    modelLast = 1'b1; expRdata[0] = '0; expRdata[1] = '0;
    @(negedge clk);
    rstL = 1'b1;
    ackSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0) ackSeen++;
    end
    checks++;
    if (ackSeen !== 0) begin
      errors++; $display("[TB] FAIL rstmid_noack got %0d acks want 0", ackSeen);
    end
    din = $urandom;
    bus.data_in = din;
    applyStimulus(1'b1, 1'b0, 10'h044, 32'h0);
    waitAck(20);
    checks++;
    if (obsCycles !== RAM_LAT + 1 || obsWho !== 1'b1 || obsR1 !== din || obsR0 !== 32'h0) begin
      errors++; $display("[TB] FAIL rstmid_recover got cyc=%0d who=%b r1=%h r0=%h want %0d 1 %h 0", obsCycles, obsWho, obsR1, obsR0, RAM_LAT + 1, din);
    end
    expRdata[1] = din; modelLast = 1'b1;
    dropReq(1'b1);
    @(negedge clk);
  endtask

  task automatic test_loader_clear();
    int m1Acks = 0, m0Acks = 0, totalCyc = 0, addrErrs = 0;
    bus.m0_req = 1'b0;
    applyStimulus(1'b1, 1'b1, 10'h000, 32'h0);
    for (int i = 0; i < 256; i++) begin
      waitAck(20);
      totalCyc += obsCycles;
      if (obsWho === 1'b1) m1Acks++;
      else                 m0Acks++;
      checks++;
      if (obsAddr !== 10'(i * 4)) begin
        errors++; addrErrs++;
        if (addrErrs <= 4) $display("[TB] FAIL clear_addr%0d got %h want %h", i, obsAddr, 10'(i * 4));
      end
      bus.m1_addr = 10'((i + 1) * 4);
    end
    dropReq(1'b1); modelLast = 1'b1;
    checks++;
    if (m1Acks !== 256 || m0Acks !== 0) begin
      errors++; $display("[TB] FAIL clear_acks got m1=%0d m0=%0d want 256 0", m1Acks, m0Acks);
    end
    checks++;
    if (totalCyc !== (RAM_LAT + 1) + 255 * (RAM_LAT + 2)) begin
      errors++; $display("[TB] FAIL clear_throughput got %0d cycles want %0d", totalCyc, (RAM_LAT + 1) + 255 * (RAM_LAT + 2));
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          pend [2];
    logic        wes  [2];
    logic [9:0]  adrs [2];
    logic [31:0] wds  [2];
    logic [31:0] din;
    logic [9:0]  expAddr;
    logic [1:0]  expSel;
    logic        expWeL;
    logic [31:0] expDout;
    bit          w, first;
    for (int it = 0; it < 40; it++) begin
      int pick = $urandom_range(1, 3);
      pend[0] = pick[0]; pend[1] = pick[1];
      din = $urandom;
      bus.data_in = din;
      for (int m = 0; m < 2; m++) begin
        wes[m] = $urandom_range(0, 1); adrs[m] = 10'($urandom_range(0, 1023)); wds[m] = $urandom;
        if (pend[m]) applyStimulus(m[0], wes[m], adrs[m], wds[m]);
      end
      first = 1'b1;
      while (pend[0] || pend[1]) begin
        w = predictWinner(pend[0], pend[1], modelLast);
        waitAck(20);
        expAddr = {adrs[w][9:2], 2'b00};
        expSel  = (expAddr < IO_BASE) ? 2'b10 : 2'b01;
        expWeL  = ~wes[w];
        expDout = wes[w] ? wds[w] : 32'h0;
        if (!wes[w]) expRdata[w] = din;
        modelLast = w;
        checks++;
        if (obsWho !== w || obsGrant !== w || obsCycles !== (first ? RAM_LAT + 1 : RAM_LAT + 2) || obsBothAck !== 1'b0) begin
          errors++; $display("[TB] FAIL rand%0d_grant got who=%b gnt=%b cyc=%0d want who=%b", it, obsWho, obsGrant, obsCycles, w);
        end
        checks++;
        if (obsAddr !== expAddr || obsWeL !== expWeL || obsDout !== expDout || obsAsLow !== RAM_LAT) begin
          errors++; $display("[TB] FAIL rand%0d_bus got a=%h weL=%b d=%h n=%0d want a=%h weL=%b d=%h", it, obsAddr, obsWeL, obsDout, obsAsLow, expAddr, expWeL, expDout);
        end
        checks++;
        if ({obsRam, obsIo} !== expSel) begin
          errors++; $display("[TB] FAIL rand%0d_sel got %b%b want %b", it, obsRam, obsIo, expSel);
        end
        checks++;
        if (obsR0 !== expRdata[0] || obsR1 !== expRdata[1]) begin
          errors++; $display("[TB] FAIL rand%0d_rdata got %h %h want %h %h", it, obsR0, obsR1, expRdata[0], expRdata[1]);
        end
        dropReq(w);
        pend[w] = 1'b0;
        first = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] data_bus_arbiter bench start");
    test_reset();
    test_m1_write();
    test_m0_read();
    test_back_to_back();
    test_io_decode();
    test_reset_mid();
    test_loader_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
